// File: rtl/approx_mult_ctrl.sv
// approx_mult_ctrl: sequencer for the approximate-multiplier datapath.
//
// Reads N_PAIRS operand pairs from the input RAM. Operand A of pair k is at
// address 2k and operand B is at 2k+1. For each pair the controller:
//   - loads both 16-bit shift registers;
//   - shifts each one left until its MSB is set (leading-one normalization),
//     counting the shifts, or stops after 16 shifts for a zero operand;
//   - captures the top bytes into the 8-bit multiplier registers;
//   - writes the product to output RAM address k.
//
// Optional feature: define APPROX_MULT_PERF_CNT_EN to add a 16-bit cycle_cnt
// output that counts busy cycles of the last run and saturates at 0xFFFF.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a run (sampled only in IDLE)
//   a_msb, b_msb       bit 15 of shift registers A / B
//   busy, done         run in progress / single-cycle completion pulse
//   in_adr             input RAM read address
//   ld_a, ld_b         load shift register A / B from RAM data
//   shl_a, shl_b       shift A / B left by one
//   ld_mul             load the multiplier registers from the top bytes
//   out_we, out_adr    output RAM write strobe and address (k)
//   sa, sb             shift counts of A / B (0..16)
//   sh_sum             sa + sb, used to align the product
//   zero               either operand was zero; the datapath writes 0
//   cycle_cnt          (optional) busy-cycle count of the last run
module approx_mult_ctrl #(
  parameter int unsigned N_PAIRS   = 8,
  parameter int unsigned IN_ADR_W  = 4,
  parameter int unsigned OUT_ADR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 a_msb,
  input  logic                 b_msb,
  output logic                 busy,
  output logic                 done,
  output logic [IN_ADR_W-1:0]  in_adr,
  output logic                 ld_a,
  output logic                 ld_b,
  output logic                 shl_a,
  output logic                 shl_b,
  output logic                 ld_mul,
  output logic                 out_we,
  output logic [OUT_ADR_W-1:0] out_adr,
  output logic [4:0]           sa,
  output logic [4:0]           sb,
  output logic [5:0]           sh_sum,
`ifdef APPROX_MULT_PERF_CNT_EN
  output logic [15:0]          cycle_cnt,
`endif
  output logic                 zero
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StNorm,
    StCapture,
    StWrite,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [OUT_ADR_W-1:0] k_q, k_d;
  logic [4:0]           sa_q, sa_d;
  logic [4:0]           sb_q, sb_d;

  logic                 need_a, need_b;
  logic                 last_pair;
  logic [IN_ADR_W-1:0]  pair_base;

  // Even address of pair k; the odd partner only sets bit 0.
  assign pair_base = IN_ADR_W'({k_q, 1'b0});
  assign last_pair = (k_q == OUT_ADR_W'(N_PAIRS - 1));

  // A zero operand never raises its MSB, so the count saturates at 16.
  assign need_a = !a_msb && (sa_q < 5'd16);
  assign need_b = !b_msb && (sb_q < 5'd16);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    in_adr  = '0;
    out_adr = '0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    shl_a   = 1'b0;
    shl_b   = 1'b0;
    ld_mul  = 1'b0;
    out_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_d     = '0;
          sa_d    = '0;
          sb_d    = '0;
          state_d = StLoadA;
        end
      end
      StLoadA: begin
        in_adr  = pair_base;
        ld_a    = 1'b1;
        state_d = StLoadB;
      end
      StLoadB: begin
        in_adr  = pair_base | IN_ADR_W'(1);
        ld_b    = 1'b1;
        sa_d    = '0;
        sb_d    = '0;
        state_d = StNorm;
      end
      StNorm: begin
        shl_a = need_a;
        shl_b = need_b;
        if (need_a) sa_d = sa_q + 5'd1;
        if (need_b) sb_d = sb_q + 5'd1;
        if (!need_a && !need_b) state_d = StCapture;
      end
      StCapture: begin
        ld_mul  = 1'b1;
        state_d = StWrite;
      end
      StWrite: begin
        out_we  = 1'b1;
        out_adr = k_q;
        if (last_pair) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + OUT_ADR_W'(1);
          state_d = StLoadA;
        end
      end
      StDone: begin
        k_d     = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign sa     = sa_q;
  assign sb     = sb_q;
  assign sh_sum = {1'b0, sa_q} + {1'b0, sb_q};
  assign zero   = (sa_q == 5'd16) || (sb_q == 5'd16);

`ifdef APPROX_MULT_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      if (start) cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Scoreboard bench for approx_mult_ctrl: a behavioural datapath model (RAM and
// shift registers) feeds a_msb/b_msb; expectations per pair come from leading
// zero counts of the operands and are checked by an independent monitor.
module tb_approx_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        a_msb, b_msb;
  logic        busy, done;
  logic [3:0]  in_adr;
  logic        ld_a, ld_b, shl_a, shl_b, ld_mul, out_we;
  logic [2:0]  out_adr;
  logic [4:0]  sa, sb;
  logic [5:0]  sh_sum;
  logic        zero;
`ifdef APPROX_MULT_PERF_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  approx_mult_ctrl #(
    .N_PAIRS  (8),
    .IN_ADR_W (4),
    .OUT_ADR_W(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_msb    (a_msb),
    .b_msb    (b_msb),
    .busy     (busy),
    .done     (done),
    .in_adr   (in_adr),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .shl_a    (shl_a),
    .shl_b    (shl_b),
    .ld_mul   (ld_mul),
    .out_we   (out_we),
    .out_adr  (out_adr),
    .sa       (sa),
    .sb       (sb),
    .sh_sum   (sh_sum),
`ifdef APPROX_MULT_PERF_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Datapath model: input RAM plus the two shift registers.
  logic [15:0] mem [16];
  logic [15:0] sr_a, sr_b;

  always @(posedge clk) begin
    if (ld_a)       sr_a <= mem[in_adr];
    else if (shl_a) sr_a <= {sr_a[14:0], 1'b0};
    if (ld_b)       sr_b <= mem[in_adr];
    else if (shl_b) sr_b <= {sr_b[14:0], 1'b0};
  end

  assign a_msb = sr_a[15];
  assign b_msb = sr_b[15];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int adr;
    int sa;
    int sb;
    int lat;
  } exp_t;

  exp_t exp_q[$];

  // Shifts needed to bring the leading one to bit 15; 16 for a zero word.
  function automatic int lz16(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return 15 - i;
    return 16;
  endfunction

  task automatic push_run(output int total);
    int ea, eb, mx;
    exp_t e;
    total = 1;
    for (int k = 0; k < 8; k++) begin
      ea = lz16(mem[2*k]);
      eb = lz16(mem[2*k+1]);
      mx = (ea > eb) ? ea : eb;
      e.adr = k;
      e.sa  = ea;
      e.sb  = eb;
      e.lat = 5 + mx;
      exp_q.push_back(e);
      total += 5 + mx;
    end
  endtask

  // Monitor: checks addresses, shift counts and per-pair latency on each write.
  int cyc = 0;
  int exp_adr = 0;
  int pair_start = 0;
  int na = 0;
  int nb = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
      end else begin
        if (!busy) exp_adr = 0;
        if (ld_a) begin
          chk("in_adr_a", int'(in_adr), exp_adr);
          exp_adr++;
          pair_start = cyc;
          na = 0;
          nb = 0;
        end
        if (ld_b) begin
          chk("in_adr_b", int'(in_adr), exp_adr);
          exp_adr++;
        end
        if (shl_a) na++;
        if (shl_b) nb++;
        if (out_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_adr", int'(out_adr), e.adr);
            chk("sa", int'(sa), e.sa);
            chk("sb", int'(sb), e.sb);
            chk("sh_sum", int'(sh_sum), e.sa + e.sb);
            chk("zero", int'(zero), int'(e.sa == 16 || e.sb == 16));
            chk("shl_a_count", na, e.sa);
            chk("shl_b_count", nb, e.sb);
            chk("pair_latency", cyc - pair_start + 1, e.lat);
          end
        end
      end
    end
  end

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    v = 16'($urandom);
    return v >> $urandom_range(0, 16);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = rnd_op();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_run(input bit ign);
    int total, bcnt, dcnt;
    bit seen;
    push_run(total);
    pulse_start();
    bcnt = 0;
    dcnt = 0;
    seen = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        seen = 1;
      end
      if (ign && bcnt == 10) start = 1'b1;
      if (ign && bcnt == 12) start = 1'b0;
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("busy_cycles", bcnt, total);
    chk("done_pulses", dcnt, 1);
    // Start during DONE must not re-trigger.
    if (ign) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
    end
`ifdef APPROX_MULT_PERF_CNT_EN
    chk("cycle_cnt", int'(cycle_cnt), total);
`endif
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int total;
    bit hit;
    rst = 1'b1;
    start = 1'b0;
    sr_a = '0;
    sr_b = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sa", int'(sa), 0);
    chk("rst_sb", int'(sb), 0);
    chk("rst_strobes", int'({ld_a, ld_b, shl_a, shl_b, ld_mul, out_we}), 0);
    chk("rst_in_adr", int'(in_adr), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed corner pairs, remainder random.
    fill_random();
    mem[0] = 16'h8000; mem[1] = 16'h8000;
    mem[2] = 16'h0001; mem[3] = 16'h00FF;
    mem[4] = 16'h0000; mem[5] = 16'h4000;
    mem[6] = 16'h0000; mem[7] = 16'h0000;
    do_run(1'b0);

    // All normalized: 8 * 5 + 1 busy cycles.
    for (int i = 0; i < 16; i++) mem[i] = 16'h8000;
    do_run(1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      do_run(r == 1);
    end

    // Abort during NORM of pair 3.
    fill_random();
    mem[6] = 16'h0001;
    mem[7] = 16'h0003;
    push_run(total);
    pulse_start();
    hit = 0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      @(negedge clk);
      if (ld_a && in_adr == 4'd6) hit = 1;
    end
    if (!hit) chk("abort_reach_pair3", 0, 1);
    hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      if (shl_a) hit = 1;
    end
    if (!hit) chk("abort_reach_norm", 0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_we", int'(out_we), 0);
    chk("abort_sa", int'(sa), 0);
    chk("abort_sb", int'(sb), 0);
    repeat (20) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_queue", exp_q.size(), 0);

    fill_random();
    do_run(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mult_ctrl.md
Name: approx_mult_ctrl

Overview:
- FSM sequencer for the approximate-multiplier datapath.
- Walks N_PAIRS operand pairs out of the 16x16 input RAM. Operand A sits at address 2k and operand B at 2k+1.
- For each pair it:
  - drives the two 16-bit shift registers for leading-one normalization;
  - counts the shifts on each operand;
  - captures the top bytes into the 8-bit multiplier registers;
  - writes the shifted product to output RAM address k.
- Owns the address counter, the pair counter and both shift counters.

Parameters:
N_PAIRS, 8, number of operand pairs processed per start (1..8)
IN_ADR_W, 4, input RAM address width
OUT_ADR_W, 3, output RAM address width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin a run; sampled only in IDLE
a_msb  in  1  bit 15 of shift register A
b_msb  in  1  bit 15 of shift register B
busy  out  1  high from the cycle after start until DONE inclusive
done  out  1  single-cycle pulse in DONE
in_adr  out  IN_ADR_W  input RAM read address
ld_a  out  1  load shift register A from RAM data
ld_b  out  1  load shift register B from RAM data
shl_a  out  1  shift A left by one
shl_b  out  1  shift B left by one
ld_mul  out  1  load both 8-bit multiplier registers from the shift-register top bytes
out_we  out  1  output RAM write enable
out_adr  out  OUT_ADR_W  output RAM write address (equals k)
sa  out  5  shift count of A (0..16)
sb  out  5  shift count of B (0..16)
sh_sum  out  6  sa+sb; the datapath shifts the product left by 16 minus sh_sum, or right when sh_sum>16
zero  out  1  sa==16 or sb==16; the datapath forces the written word to 0

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. While rst=1, state goes to IDLE and k, sa and sb are cleared. The registered outputs (busy, done, k, sa, sb) are 0 one cycle after rst is sampled. The strobes and addresses are decoded from IDLE, so they are 0 immediately.
- A rst in any state, including mid-NORM or in WRITE, aborts the run with no output write.
- Strobe rule: all strobes are decoded from the state and are 0 outside the states listed below.
- IDLE:
  - All strobes are 0.
  - start=1 clears k, sa and sb and moves to LOAD_A.
- LOAD_A:
  - in_adr=2k, ld_a=1.
  - Next state is LOAD_B.
- LOAD_B:
  - in_adr=2k+1, ld_b=1, and sa and sb clear.
  - Next state is NORM.
- NORM:
  - need_a = !a_msb && sa<16, and need_b = !b_msb && sb<16.
  - shl_a=need_a and shl_b=need_b. sa increments when need_a, and sb increments when need_b.
  - When both needs are 0, move to CAPTURE.
  - NORM lasts max(sa_final, sb_final)+1 cycles.
- Saturation: a zero operand saturates its count at 16 after 16 shifts and is never shifted further.
- CAPTURE:
  - ld_mul=1.
  - Next state is WRITE.
- WRITE:
  - out_we=1 and out_adr=k.
  - sa, sb, sh_sum and zero hold their final values through this cycle.
  - If k==N_PAIRS-1, move to DONE. Otherwise k increments and the FSM moves to LOAD_A.
- DONE:
  - done=1 and busy=1.
  - Next state is IDLE; k clears.
- Latency:
  - Per pair: 5+max(sa,sb) cycles.
  - Whole run: the sum over all pairs plus 1 cycle for DONE.
- start behaviour:
  - start while busy is ignored.
  - start held high re-triggers only once the FSM is back in IDLE, i.e. the cycle after DONE.
- Arithmetic:
  - sh_sum is a 6-bit unsigned sum with no overflow (maximum 32).
  - Address arithmetic 2k+1 stays within IN_ADR_W for N_PAIRS<=8.

Optional Feature:
- Macro: APPROX_MULT_PERF_CNT_EN.
- When defined, a 16-bit output port cycle_cnt is added.
  - It clears on a start accepted in IDLE and increments every cycle while busy.
  - It holds its value after DONE until the next start.
  - It saturates at 0xFFFF.
  - It resets to 0.
- When undefined, the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Normalized pair: A=0x8000, B=0x8000, N_PAIRS=1 -> sa=0, sb=0, sh_sum=0, zero=0. NORM is 1 cycle, out_we occurs at cycle 5 after start, and done follows at cycle 6.
- Deep shift: A=0x0001, B=0x00FF -> sa=15, sb=8, sh_sum=23. shl_a is asserted for 15 cycles and shl_b for 8, NORM lasts 16 cycles, and the pair takes 20 cycles.
- Zero operand: A=0x0000, B=0x4000 -> sa=16 with shl_a asserted exactly 16 times, sb=1, zero=1 during WRITE.
- Full run: 8 pairs, all 0x8000 -> out_adr sequence 0..7 with one out_we each, in_adr sequence 0..15, busy for 41 cycles, a single done pulse. With APPROX_MULT_PERF_CNT_EN defined, cycle_cnt=41.
- Reset mid-operation: rst during NORM of pair 3 -> next cycle IDLE, busy=0, no out_we. A fresh start then restarts at in_adr=0.
- Ignored start: start pulsed during NORM and during DONE -> no effect on the running sequence, and the FSM stays in IDLE afterwards unless start is high while in IDLE.
